// File: rtl/sa2_job_scheduler.sv
// Purpose: arbitrates two requesters onto one systolic_array_2_by_2 and sequences each job (latch, clear, run, respond).
// Latency: accept to rspN_valid is 31 cycles; one job per 32 cycles when the response is taken at once.
// Backpressure: reqN_ready only in IDLE for the round-robin winner; RESP holds c/err until rsp[grant_id]_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready/a/b        job request from requester N (a: 4x4 tile, b: 3x3 filter, row-major bytes)
//   rspN_valid/ready/c/err      2x2 result (c11..c22 bytes) and watchdog-abort flag back to requester N
//   sa_rst, sa_active           array reset (high) and run enable
//   sa_a, sa_b, sa_done, sa_c   array operands, completion strobe and result
//   busy, grant_id, jobs_done   status: not idle, owner of current job, completed-job count
//
// Build option: define SA_SCHED_WATCHDOG_EN to abort jobs that stay in RUN for WDOG_CYCLES.
module sa2_job_scheduler #(
  parameter int unsigned WDOG_CYCLES = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_a,
  input  logic [71:0]  req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_a,
  input  logic [71:0]  req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [31:0]  rsp0_c,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [31:0]  rsp1_c,
  output logic         rsp1_err,
  output logic         sa_rst,
  output logic         sa_active,
  output logic [127:0] sa_a,
  output logic [71:0]  sa_b,
  input  logic         sa_done,
  input  logic [31:0]  sa_c,
  output logic         busy,
  output logic         grant_id,
  output logic [15:0]  jobs_done
);

  if (WDOG_CYCLES < 30 || WDOG_CYCLES > 255) begin : g_wdog_range
    $error("WDOG_CYCLES must be within 30..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   rr_ptr;    // requester that was not served last; wins a tie
  logic   win0;
  logic   win1;
  logic   rsp_take;

  // A lone requester always wins; on a tie the pointer decides.
  assign win0       = req0_valid && (!req1_valid || !rr_ptr);
  assign win1       = req1_valid && (!req0_valid ||  rr_ptr);
  assign req0_ready = (state == IDLE) && win0;
  assign req1_ready = (state == IDLE) && win1;
  assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;

`ifdef SA_SCHED_WATCHDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  logic [7:0] wdog_cnt;
  logic       wdog_hit;

  // The count is preloaded with 1 on leaving CLR, so it would reach
  // WDOG_CYCLES on the abort edge: the error response appears
  // WDOG_CYCLES+1 cycles after accept.
  assign wdog_hit = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      if (state == CLR) begin
        wdog_cnt <= 8'd1;
      end else if (state == RUN) begin
        wdog_cnt <= wdog_cnt + 8'd1;
        if (!sa_done && wdog_hit) begin
          if (grant_id) rsp1_err <= 1'b1;
          else          rsp0_err <= 1'b1;
        end
      end else if (state == RESP && rsp_take) begin
        rsp0_err <= 1'b0;
        rsp1_err <= 1'b0;
      end
    end
  end
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      sa_rst     <= 1'b1;   // array is held in reset together with this block
      sa_active  <= 1'b0;
      sa_a       <= '0;
      sa_b       <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_c     <= '0;
      rsp1_c     <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      jobs_done  <= '0;
    end else begin
      sa_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            sa_a     <= req1_ready ? req1_a : req0_a;
            sa_b     <= req1_ready ? req1_b : req0_b;
            grant_id <= req1_ready;
            // One-cycle clear so the accumulators never sum across jobs.
            sa_rst   <= 1'b1;
            busy     <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          sa_active <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (sa_done) begin
            if (grant_id) begin
              rsp1_valid <= 1'b1;
              rsp1_c     <= sa_c;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_c     <= sa_c;
            end
            jobs_done <= jobs_done + 16'd1;
            rr_ptr    <= ~rr_ptr;
            sa_active <= 1'b0;
            state     <= RESP;
          end
`ifdef SA_SCHED_WATCHDOG_EN
          else if (wdog_hit) begin
            // Abort: c stays at its idle value of zero, array is cleared.
            if (grant_id) rsp1_valid <= 1'b1;
            else          rsp0_valid <= 1'b1;
            sa_rst    <= 1'b1;
            rr_ptr    <= ~rr_ptr;
            sa_active <= 1'b0;
            state     <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_c     <= '0;
            rsp1_c     <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa2_job_scheduler.sv
module tb_sa2_job_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_a = '0, req1_a = '0;
  logic [71:0]  req0_b = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0]  rsp0_c, rsp1_c;
  logic         rsp0_err, rsp1_err;
  logic         sa_rst, sa_active, sa_done;
  logic [127:0] sa_a;
  logic [71:0]  sa_b;
  logic [31:0]  sa_c;
  logic         busy, grant_id;
  logic [15:0]  jobs_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] c;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  always #5 clk = ~clk;

  sa2_job_scheduler #(.WDOG_CYCLES(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_err(rsp1_err),
    .sa_rst(sa_rst), .sa_active(sa_active), .sa_a(sa_a), .sa_b(sa_b),
    .sa_done(sa_done), .sa_c(sa_c),
    .busy(busy), .grant_id(grant_id), .jobs_done(jobs_done)
  );

  // 2x2 valid convolution of a 4x4 tile with a 3x3 filter, bytes wrap.
  function automatic logic [31:0] conv(input logic [127:0] a, input logic [71:0] b);
    logic [31:0] c;
    logic [7:0]  s;
    c = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = '0;
        for (int r = 0; r < 3; r++)
          for (int q = 0; q < 3; q++)
            s = s + a[((i + r) * 4 + (j + q)) * 8 +: 8] * b[(r * 3 + q) * 8 +: 8];
        c[(i * 2 + j) * 8 +: 8] = s;
      end
    return c;
  endfunction

  function automatic exp_t mk(input logic id, input logic [31:0] c, input logic err);
    exp_t e;
    e.id = id; e.c = c; e.err = err;
    return e;
  endfunction

  // Behavioural array: steps S0..S28 while active, done at S28, accumulates
  // one convolution per run until sa_rst clears it.
  logic [7:0]  st;
  logic [31:0] acc;
  logic [31:0] cv_w;
  logic        hang = 1'b0;
  assign cv_w    = conv(sa_a, sa_b);
  assign sa_done = sa_active && (st == 8'd28) && !hang;
  assign sa_c    = acc;
  always @(posedge clk) begin
    if (sa_rst) begin
      st  <= '0;
      acc <= '0;
    end else if (sa_active) begin
      st <= st + 8'd1;
      if (st == 8'd27)
        for (int k = 0; k < 4; k++) acc[k * 8 +: 8] <= acc[k * 8 +: 8] + cv_w[k * 8 +: 8];
    end
  end

  // Scoreboard: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (rsp0_valid && rsp0_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL sb_unexpected rsp0 c=%h err=%b", rsp0_c, rsp0_err); end
        else begin
          mon_x = sb.pop_front();
          if (mon_x.id !== 1'b0 || mon_x.c !== rsp0_c || mon_x.err !== rsp0_err) begin
            errors++;
            $display("FAIL sb_rsp0 got c=%h err=%b want id=%0d c=%h err=%b", rsp0_c, rsp0_err, mon_x.id, mon_x.c, mon_x.err);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL sb_unexpected rsp1 c=%h err=%b", rsp1_c, rsp1_err); end
        else begin
          mon_x = sb.pop_front();
          if (mon_x.id !== 1'b1 || mon_x.c !== rsp1_c || mon_x.err !== rsp1_err) begin
            errors++;
            $display("FAIL sb_rsp1 got c=%h err=%b want id=%0d c=%h err=%b", rsp1_c, rsp1_err, mon_x.id, mon_x.c, mon_x.err);
          end
        end
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1; hang = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sa_rst !== 1'b1) begin errors++; $display("FAIL rst_sa_rst got %b want 1", sa_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (sa_active !== 1'b0) begin errors++; $display("FAIL rst_sa_active got %b want 0", sa_active); end
    checks++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0) begin errors++; $display("FAIL rst_rsp_flags got %b want 0000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
    checks++; if ({rsp0_c, rsp1_c} !== 64'd0) begin errors++; $display("FAIL rst_rsp_c got %h want 0", {rsp0_c, rsp1_c}); end
    checks++; if (grant_id !== 1'b0 || jobs_done !== 16'd0) begin errors++; $display("FAIL rst_status got grant=%b jobs=%0d want 0 0", grant_id, jobs_done); end
    checks++; if (sa_a !== 128'd0 || sa_b !== 72'd0) begin errors++; $display("FAIL rst_operands got a=%h b=%h want 0", sa_a, sa_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (sa_rst !== 1'b0) begin errors++; $display("FAIL rst_release_sa_rst got %b want 0", sa_rst); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready got %b%b want 00", req0_ready, req1_ready); end
  endtask

  task automatic test_single;
    int  lat = 0;
    bit  seen1 = 0;
    req0_a = {16{8'h01}}; req0_b = {9{8'h01}}; req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
    sb.push_back(mk(1'b0, 32'h09090909, 1'b0));
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req0_valid = 1'b0;
        checks++; if (sa_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_clr got sa_rst=%b busy=%b want 1 1", sa_rst, busy); end
      end
      if (n == 2) begin
        checks++; if (sa_active !== 1'b1 || sa_rst !== 1'b0) begin errors++; $display("FAIL single_run got active=%b sa_rst=%b want 1 0", sa_active, sa_rst); end
      end
      if (rsp1_valid) seen1 = 1;
      if (rsp0_valid) begin lat = n; break; end
    end
    checks++; if (lat != 31) begin errors++; $display("FAIL single_latency got %0d want 31", lat); end
    checks++; if (rsp0_c !== 32'h09090909) begin errors++; $display("FAIL single_c got %h want 09090909", rsp0_c); end
    checks++; if (sa_active !== 1'b0) begin errors++; $display("FAIL single_active_fall got %b want 0", sa_active); end
    @(negedge clk);
    if (rsp1_valid) seen1 = 1;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b valid=%b want 0 0", busy, rsp0_valid); end
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL single_jobs got %0d want 1", jobs_done); end
    checks++; if (seen1) begin errors++; $display("FAIL single_rsp1_quiet got 1 want 0"); end
  endtask

  task automatic test_both;
    logic [127:0] a0, a1;
    logic [71:0]  b0, b1;
    int           acc_n = 0;
    bit           drained = 0;
    do_reset();
    a0 = {$urandom(), $urandom(), $urandom(), $urandom()}; b0 = {8'($urandom()), $urandom(), $urandom()};
    a1 = {$urandom(), $urandom(), $urandom(), $urandom()}; b1 = {8'($urandom()), $urandom(), $urandom()};
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_first_winner got %b%b want 10", req0_ready, req1_ready); end
    sb.push_back(mk(1'b0, conv(a0, b0), 1'b0));
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req0_valid = 1'b0;
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL both_grant0 got %b want 0", grant_id); end
      end
      if (req1_ready) begin acc_n = n; break; end
    end
    checks++; if (acc_n != 32) begin errors++; $display("FAIL both_second_accept got cycle %0d want 32", acc_n); end
    sb.push_back(mk(1'b1, conv(a1, b1), 1'b0));
    @(negedge clk);
    req1_valid = 1'b0;
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL both_grant1 got %b want 1", grant_id); end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy && !rsp1_valid) begin drained = 1; break; end
    end
    @(negedge clk);
    checks++; if (!drained || sb.size() != 0) begin errors++; $display("FAIL both_drained got pending=%0d idle=%0d want 0 1", sb.size(), drained); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] a;
    logic [71:0]  b;
    logic [31:0]  c_first = '0, c_second = '1;
    int           acc_cyc[2];
    int           nacc = 0, nrsp = 0, rst_cnt = 0;
    bit           drop = 0;
    do_reset();
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    a = {$urandom(), $urandom(), $urandom(), $urandom()}; b = {8'($urandom()), $urandom(), $urandom()};
    req0_a = a; req0_b = b; req0_valid = 1'b1;
    #1;
    for (int n = 0; n < 120; n++) begin
      if (n > 0) @(negedge clk);
      if (drop) req0_valid = 1'b0;
      if (sa_rst === 1'b1) rst_cnt++;
      if (rsp0_valid) begin
        if (nrsp == 0) c_first = rsp0_c; else c_second = rsp0_c;
        nrsp++;
      end
      if (req0_valid && req0_ready) begin
        if (nacc < 2) acc_cyc[nacc] = n;
        nacc++;
        sb.push_back(mk(1'b0, conv(a, b), 1'b0));
        if (nacc == 2) drop = 1;
      end
      if (nrsp == 2) break;
    end
    checks++; if (nrsp != 2 || nacc != 2) begin errors++; $display("FAIL b2b_count got acc=%0d rsp=%0d want 2 2", nacc, nrsp); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 32) begin errors++; $display("FAIL b2b_spacing got %0d want 32", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (c_first !== conv(a, b)) begin errors++; $display("FAIL b2b_first_c got %h want %h", c_first, conv(a, b)); end
    checks++; if (c_second !== c_first) begin errors++; $display("FAIL b2b_no_accum got %h want %h", c_second, c_first); end
    checks++; if (rst_cnt != 2) begin errors++; $display("FAIL b2b_sa_rst_pulses got %0d want 2", rst_cnt); end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd2) begin errors++; $display("FAIL b2b_jobs got %0d want 2", jobs_done); end
  endtask

  task automatic test_rsp_hold;
    logic [127:0] a0, a1;
    logic [71:0]  b0, b1;
    bit           got = 0, drained = 0;
    do_reset();
    a0 = {$urandom(), $urandom(), $urandom(), $urandom()}; b0 = {8'($urandom()), $urandom(), $urandom()};
    a1 = {$urandom(), $urandom(), $urandom(), $urandom()}; b1 = {8'($urandom()), $urandom(), $urandom()};
    rsp0_ready = 1'b0;
    req0_a = a0; req0_b = b0; req0_valid = 1'b1;
    #1;
    sb.push_back(mk(1'b0, conv(a0, b0), 1'b0));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_a = a1; req1_b = b1; req1_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rsp0_valid) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL hold_rsp_timeout got none want rsp0_valid"); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({rsp0_valid, rsp0_c, req1_ready} !== {1'b1, conv(a0, b0), 1'b0}) begin
        errors++; $display("FAIL hold_stable k=%0d got v=%b c=%h r1=%b want 1 %h 0", k, rsp0_valid, rsp0_c, req1_ready, conv(a0, b0));
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_req1_after got %b want 1", req1_ready); end
    sb.push_back(mk(1'b1, conv(a1, b1), 1'b0));
    @(negedge clk);
    req1_valid = 1'b0;
    checks++; if (grant_id !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL hold_grant1 got grant=%b rsp0v=%b want 1 0", grant_id, rsp0_valid); end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy && !rsp1_valid) begin drained = 1; break; end
    end
    @(negedge clk);
    checks++; if (!drained || sb.size() != 0) begin errors++; $display("FAIL hold_drained got pending=%0d idle=%0d want 0 1", sb.size(), drained); end
  endtask

  task automatic test_reset_mid;
    bit any_rsp = 0;
    do_reset();
    req1_a = {$urandom(), $urandom(), $urandom(), $urandom()}; req1_b = {8'($urandom()), $urandom(), $urandom()};
    req1_valid = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) req1_valid = 1'b0;
    end
    checks++; if (sa_active !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL midrst_pre got active=%b grant=%b want 1 1", sa_active, grant_id); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, sa_active, sa_rst, grant_id, rsp0_valid, rsp1_valid} !== 6'b001000) begin
      errors++; $display("FAIL midrst_outputs got busy=%b act=%b sa_rst=%b grant=%b v=%b%b want 0 0 1 0 00", busy, sa_active, sa_rst, grant_id, rsp0_valid, rsp1_valid);
    end
    checks++; if (sa_a !== 128'd0 || sa_b !== 72'd0) begin errors++; $display("FAIL midrst_operands got a=%h b=%h want 0", sa_a, sa_b); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) any_rsp = 1;
    end
    checks++; if (any_rsp || busy !== 1'b0 || jobs_done !== 16'd0) begin errors++; $display("FAIL midrst_after got rsp=%0d busy=%b jobs=%0d want 0 0 0", any_rsp, busy, jobs_done); end
  endtask

  task automatic test_watchdog;
    do_reset();
    hang = 1'b1;
    req0_a = {$urandom(), $urandom(), $urandom(), $urandom()}; req0_b = {8'($urandom()), $urandom(), $urandom()};
    req0_valid = 1'b1;
`ifdef SA_SCHED_WATCHDOG_EN
    begin
      int lat = 0;
      #1;
      sb.push_back(mk(1'b0, 32'd0, 1'b1));
      for (int n = 1; n <= 80; n++) begin
        @(negedge clk);
        if (n == 1) req0_valid = 1'b0;
        if (rsp0_valid) begin lat = n; break; end
      end
      checks++; if (lat != 41) begin errors++; $display("FAIL wdog_latency got %0d want 41", lat); end
      checks++; if (rsp0_err !== 1'b1 || rsp0_c !== 32'd0) begin errors++; $display("FAIL wdog_rsp got err=%b c=%h want 1 0", rsp0_err, rsp0_c); end
      checks++; if (sa_rst !== 1'b1) begin errors++; $display("FAIL wdog_sa_rst got %b want 1", sa_rst); end
      @(negedge clk);
      checks++; if (sa_rst !== 1'b0 || jobs_done !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL wdog_after got sa_rst=%b jobs=%0d busy=%b want 0 0 0", sa_rst, jobs_done, busy); end
    end
`else
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ({busy, sa_active, rsp0_valid, rsp0_err} !== 4'b1100) begin
      errors++; $display("FAIL nowdog_stuck got busy=%b act=%b v=%b err=%b want 1 1 0 0", busy, sa_active, rsp0_valid, rsp0_err);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa2_job_scheduler.md
# sa2_job_scheduler

Arbiter and sequencer that shares one `systolic_array_2_by_2` instance between two requesters. Each accepted job is one 4x4 input tile (a) plus one 3x3 filter (b), and produces one 2x2 output (c). The block latches the job's operands, clears the array, runs it to `done_sa2`, captures c, and returns it to the winning requester over a valid/ready response. It sits between the layer controllers and the array.

## Interface
Parameters:
- `WDOG_CYCLES`, default 40: cycles allowed in RUN before the watchdog aborts the job; range 30..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): requester N presents a job.
- `reqN_ready` out 1: job accepted on a cycle with `reqN_valid && reqN_ready`.
- `reqN_a` in 128: tile, row-major packing; a11 at [7:0], a12 at [15:8], …, a44 at [127:120].
- `reqN_b` in 72: filter, row-major packing; b11 at [7:0], …, b33 at [71:64].
- `rspN_valid` out 1: result available for requester N.
- `rspN_ready` in 1: requester N takes the result.
- `rspN_c` out 32: result packing c11 [7:0], c12 [15:8], c21 [23:16], c22 [31:24].
- `rspN_err` out 1: job aborted by the watchdog.
- `sa_rst` out 1: active-high reset to the array and its accumulators.
- `sa_active` out 1: drives `active_sa2`.
- `sa_a` out 128: drives a11..a44, same packing as `reqN_a`.
- `sa_b` out 72: drives b11..b33, same packing as `reqN_b`.
- `sa_done` in 1: from `done_sa2`.
- `sa_c` in 32: from c11..c22, same packing as `rspN_c`.
- `busy` out 1: state is not IDLE.
- `grant_id` out 1: requester owning the current job.
- `jobs_done` out 16: count of completed jobs; wraps 0xFFFF→0.

## Operation
- State machine, states IDLE, CLR, RUN, RESP.
- IDLE:
  - `reqN_ready` is high only for the arbitration winner.
  - Winner: if exactly one `reqN_valid` is high, that requester wins.
  - If both are valid, the round-robin pointer decides. The pointer names the requester not served last; the reset value favours requester 0.
  - On handshake: latch a/b into `sa_a`/`sa_b`, set `grant_id`, go to CLR.
- CLR: registered `sa_rst`=1 for exactly one cycle. This zeroes the array FSM and accumulators, which would otherwise sum across jobs. Go to RUN.
- RUN:
  - `sa_active`=1 and `sa_a`/`sa_b` held stable.
  - On `sa_done`=1: capture `sa_c` into the response register, `err`=0, increment `jobs_done`, flip the pointer, go to RESP.
- RESP:
  - `sa_active`=0.
  - `rsp[grant_id]_valid`=1; c and err are held stable until `rsp[grant_id]_ready`=1, then go to IDLE.
  - The other requester's rsp signals stay 0.
- A new request from either requester is never accepted outside IDLE. `reqN_valid` may stay high while waiting; the held job is accepted in a later IDLE.
- `sa_done` outside RUN is ignored.
- Reset values:
  - state=IDLE, `sa_rst`=1 while `rst_n` is low (the array is reset with the block), `sa_active`=0.
  - `sa_a`, `sa_b`, all rsp c/valid/err = 0.
  - `grant_id`=0, pointer=0, `jobs_done`=0, `busy`=0.
- Reset asserted mid-job: everything returns to reset values immediately. The job is lost and no response is issued.

## Timing
- Accept edge = cycle 0.
- Cycle 1 is CLR.
- Cycles 2..30 are RUN; the array steps S0..S28, and `sa_done` is high in cycle 30.
- `sa_c` is captured at the end of cycle 30. `rspN_valid` rises in cycle 31, i.e. accept-to-valid is 31 cycles.
- With `rspN_ready` tied high: RESP lasts 1 cycle, IDLE is reached in cycle 32, and the next job can be accepted in cycle 32. Throughput is one job per 32 cycles.
- `sa_active` falls in the cycle after `sa_done`.
- All outputs are registered except `reqN_ready`, which is combinational from state, pointer and `reqN_valid`.

## Configuration
- `SA_SCHED_WATCHDOG_EN` defined:
  - An 8-bit counter runs in RUN.
  - If it reaches `WDOG_CYCLES` without `sa_done`: go to RESP with c=0 and `err`=1, pulse `sa_rst` for one cycle, flip the pointer, and do not increment `jobs_done`.
- Not defined: no counter, RUN waits indefinitely, and `rspN_err` is tied to 0.

## Test plan
- Single job from req0 with all a=1 and all b=1, behavioural array model → `rsp0_valid` in cycle 31 with c=0x09090909, `jobs_done`=1, `rsp1_valid` stays 0.
- Both requesters valid in the same cycle after reset → req0 is served first, then req1. Each gets its own c, and `grant_id` goes 0 then 1.
- Two back-to-back jobs from req0 with the same operands → the second c equals the first (no accumulation carried over); `sa_rst` is seen high once per job.
- `rsp0_ready` held low for 10 cycles → c is stable and `req1_ready` stays 0 until `rsp0_ready` rises; req1 is accepted in the cycle after the rsp0 handshake.
- `rst_n` pulsed low in cycle 15 of RUN → all outputs are at reset values, with no response and `jobs_done` unchanged.
- With `SA_SCHED_WATCHDOG_EN` and a model that never asserts `sa_done` → `rsp0_valid` with `err`=1 and c=0, 41 cycles after accept; without the macro, `busy` stays 1.
